// File: rtl/text_writer_pkg.sv
// rtl/text_writer_pkg.sv - shared widths, attribute layout, control codes and cursor opcodes
//
// Purpose: common definitions imported by text_writer, text_cursor and text_writer_if.
// Cell word layout (VALUE_W bits): {attr_t, 8-bit character index}.
// Ports: none (package).
package text_writer_pkg;

    localparam int COL_W   = 7;   // column index width, covers up to 128 columns
    localparam int ROW_W   = 5;   // row index width, covers up to 32 rows
    localparam int COLOR_W = 4;
    localparam int SIZE_W  = 2;
    localparam int PART_W  = 2;

    typedef struct packed {
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic [SIZE_W-1:0]  size;
        logic [PART_W-1:0]  part;
        logic               blink;
        logic               underline;
    } attr_t;

    localparam int ATTR_W  = $bits(attr_t);
    localparam int VALUE_W = ATTR_W + 8;

    localparam attr_t ATTR_RESET = '{
        fg:        {COLOR_W{1'b1}},
        bg:        '0,
        size:      '0,
        part:      '0,
        blink:     1'b0,
        underline: 1'b0
    };

    localparam logic [7:0] CTRL_BS  = 8'h08;
    localparam logic [7:0] CTRL_LF  = 8'h0A;
    localparam logic [7:0] CTRL_FF  = 8'h0C;
    localparam logic [7:0] CTRL_CR  = 8'h0D;
    localparam logic [7:0] CTRL_ESC = 8'h1B;

    localparam logic [7:0] ESC_CMD_FG   = 8'h46; // 'F'
    localparam logic [7:0] ESC_CMD_BG   = 8'h42; // 'B'
    localparam logic [7:0] ESC_CMD_ATTR = 8'h41; // 'A'
    localparam logic [7:0] ESC_CMD_X    = 8'h58; // 'X'
    localparam logic [7:0] ESC_CMD_Y    = 8'h59; // 'Y'

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADVANCE,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME,
        CUR_LOAD_X,
        CUR_LOAD_Y
    } cur_op_e;

    // DEL (0x7F) is treated like a control byte and dropped.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b != 8'h7F);
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// rtl/text_writer_if.sv - byte input handshake plus video_memory write port bundle
//
// Purpose: groups the byte stream (in_data/in_valid/in_ready), status (busy, cursor)
// and the cell write port (write, xtextwrite, ytextwrite, value).
// Modports: master = byte source / memory side, slave = text_writer.
interface text_writer_if;
    import text_writer_pkg::*;

    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               busy;
    logic [COL_W-1:0]   cursor_x;
    logic [ROW_W-1:0]   cursor_y;
    logic               write;
    logic [COL_W-1:0]   xtextwrite;
    logic [ROW_W-1:0]   ytextwrite;
    logic [VALUE_W-1:0] value;

    modport master (
        output in_data, in_valid,
        input  in_ready, busy, cursor_x, cursor_y,
        input  write, xtextwrite, ytextwrite, value
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, busy, cursor_x, cursor_y,
        output write, xtextwrite, ytextwrite, value
    );

endinterface

// File: rtl/text_writer_cursor.sv
// rtl/text_writer_cursor.sv - text_cursor: x/y cursor register with advance, CR, LF, BS, home and clamped loads
//
// Purpose: holds the cursor position and applies one operation per cycle.
// Macro TEXT_WRITER_AUTOWRAP_EN: when defined, advancing past the last column
// wraps to column 0 of the next row; otherwise the cursor sticks at the last column.
// Ports: clk, rst_n (async active-low), op_i (cur_op_e), arg_i (load argument),
//        x_o/y_o (cursor position).
module text_cursor
    import text_writer_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cur_op_e          op_i,
    input  logic [7:0]       arg_i,
    output logic [COL_W-1:0] x_o,
    output logic [ROW_W-1:0] y_o
);

    localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] x_q, x_d;
    logic [ROW_W-1:0] y_q, y_d;
    logic [ROW_W-1:0] y_next;

    // No scrolling: the row index simply wraps.
    assign y_next = (y_q == Y_MAX) ? '0 : y_q + 1'b1;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (op_i)
            CUR_ADVANCE: begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
                if (x_q == X_MAX) begin
                    x_d = '0;
                    y_d = y_next;
                end else begin
                    x_d = x_q + 1'b1;
                end
`else
                if (x_q != X_MAX) begin
                    x_d = x_q + 1'b1;
                end
`endif
            end
            CUR_CR:     x_d = '0;
            CUR_LF:     y_d = y_next;
            CUR_BS:     if (x_q != '0) x_d = x_q - 1'b1;
            CUR_HOME: begin
                x_d = '0;
                y_d = '0;
            end
            CUR_LOAD_X: x_d = (arg_i > 8'(COLS - 1)) ? X_MAX : arg_i[COL_W-1:0];
            CUR_LOAD_Y: y_d = (arg_i > 8'(ROWS - 1)) ? Y_MAX : arg_i[ROW_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/text_writer.sv
// rtl/text_writer.sv - byte stream to video_memory cell writer with cursor, attributes and clear
//
// Purpose: accepts bytes over a valid/ready handshake, prints printable bytes at the
// cursor, handles CR/LF/BS/FF and two-byte ESC sequences (F, B, A, X, Y).
// Macro TEXT_WRITER_AUTOWRAP_EN (consumed by text_cursor) selects cursor autowrap.
// Ports: clk, reset (async active-low), bus (text_writer_if.slave: in_data, in_valid,
//        in_ready, busy, cursor_x, cursor_y, write, xtextwrite, ytextwrite, value).
module text_writer
    import text_writer_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         reset,
    text_writer_if.slave bus
);

    localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC_CMD,
        S_ESC_ARG,
        S_STROBE,
        S_RELEASE,
        S_CLR_SETUP,
        S_CLR_STROBE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         esc_cmd_q, esc_cmd_d;
    attr_t              attr_q, attr_d;
    logic               write_q, write_d;
    logic [COL_W-1:0]   xw_q, xw_d;
    logic [ROW_W-1:0]   yw_q, yw_d;
    logic [VALUE_W-1:0] value_q, value_d;

    logic               ready;
    logic               accept;
    cur_op_e            cur_op;
    logic [COL_W-1:0]   cur_x;
    logic [ROW_W-1:0]   cur_y;

    assign ready  = (state_q == S_IDLE) || (state_q == S_ESC_CMD) || (state_q == S_ESC_ARG);
    assign accept = bus.in_valid && ready;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk   (clk),
        .rst_n (reset),
        .op_i  (cur_op),
        .arg_i (bus.in_data),
        .x_o   (cur_x),
        .y_o   (cur_y)
    );

    // The write address registers double as the clear-sweep counters; the
    // cell value is fixed at FF time so attributes cannot change mid-sweep.
    always_comb begin
        state_d   = state_q;
        esc_cmd_d = esc_cmd_q;
        attr_d    = attr_q;
        write_d   = write_q;
        xw_d      = xw_q;
        yw_d      = yw_q;
        value_d   = value_q;
        cur_op    = CUR_NONE;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_printable(bus.in_data)) begin
                        xw_d    = cur_x;
                        yw_d    = cur_y;
                        value_d = {attr_q, bus.in_data};
                        state_d = S_STROBE;
                    end else begin
                        case (bus.in_data)
                            CTRL_CR:  cur_op = CUR_CR;
                            CTRL_LF:  cur_op = CUR_LF;
                            CTRL_BS:  cur_op = CUR_BS;
                            CTRL_FF: begin
                                xw_d    = '0;
                                yw_d    = '0;
                                value_d = {attr_q, BLANK_CHAR};
                                state_d = S_CLR_SETUP;
                            end
                            CTRL_ESC: state_d = S_ESC_CMD;
                            default: ;
                        endcase
                    end
                end
            end
            S_ESC_CMD: begin
                if (accept) begin
                    esc_cmd_d = bus.in_data;
                    state_d   = S_ESC_ARG;
                end
            end
            S_ESC_ARG: begin
                if (accept) begin
                    state_d = S_IDLE;
                    case (esc_cmd_q)
                        ESC_CMD_FG: attr_d.fg = bus.in_data[COLOR_W-1:0];
                        ESC_CMD_BG: attr_d.bg = bus.in_data[COLOR_W-1:0];
                        ESC_CMD_ATTR: begin
                            attr_d.blink     = bus.in_data[0];
                            attr_d.underline = bus.in_data[1];
                            attr_d.size      = bus.in_data[2 +: SIZE_W];
                            attr_d.part      = bus.in_data[4 +: PART_W];
                        end
                        ESC_CMD_X:  cur_op = CUR_LOAD_X;
                        ESC_CMD_Y:  cur_op = CUR_LOAD_Y;
                        default: ;
                    endcase
                end
            end
            // Address/value were loaded on the accepting edge, so write rises
            // one cycle after the address settles and falls one cycle later.
            S_STROBE: begin
                write_d = 1'b1;
                cur_op  = CUR_ADVANCE;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                write_d = 1'b0;
                state_d = S_IDLE;
            end
            S_CLR_SETUP: begin
                write_d = 1'b1;
                state_d = S_CLR_STROBE;
            end
            S_CLR_STROBE: begin
                write_d = 1'b0;
                if (xw_q == X_MAX) begin
                    if (yw_q == Y_MAX) begin
                        cur_op  = CUR_HOME;
                        state_d = S_IDLE;
                    end else begin
                        xw_d    = '0;
                        yw_d    = yw_q + 1'b1;
                        state_d = S_CLR_SETUP;
                    end
                end else begin
                    xw_d    = xw_q + 1'b1;
                    state_d = S_CLR_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            esc_cmd_q <= '0;
            attr_q    <= ATTR_RESET;
            write_q   <= 1'b0;
            xw_q      <= '0;
            yw_q      <= '0;
            value_q   <= '0;
        end else begin
            state_q   <= state_d;
            esc_cmd_q <= esc_cmd_d;
            attr_q    <= attr_d;
            write_q   <= write_d;
            xw_q      <= xw_d;
            yw_q      <= yw_d;
            value_q   <= value_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.busy       = !ready;
    assign bus.cursor_x   = cur_x;
    assign bus.cursor_y   = cur_y;
    assign bus.write      = write_q;
    assign bus.xtextwrite = xw_q;
    assign bus.ytextwrite = yw_q;
    assign bus.value      = value_q;

endmodule
